// File: rtl/turn_sequencer_pkg.sv
// Shared types and board geometry for the turn sequencer and its column height tracker.
package turn_sequencer_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    RED   = 2'b01,
    GREEN = 2'b10
  } cell_color_e;

  localparam int NUM_COLS  = 7;
  localparam int NUM_ROWS  = 6;
  localparam int NUM_CELLS = NUM_COLS * NUM_ROWS;

  typedef enum logic [2:0] {
    SELECT,
    FALL,
    WRITE,
    CHECK,
    GAME_OVER
  } seq_state_e;

endpackage

// File: rtl/turn_sequencer_column_heights.sv
// Per-column fill heights (0..NUM_ROWS); increment saturates, so a full column never wraps.
module column_heights
  import turn_sequencer_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                inc_i,
  input  logic [2:0]          inc_col_i,
  input  logic [2:0]          rd_col_i,
  output logic [2:0]          rd_height_o,
  output logic [NUM_COLS-1:0] full_o
);

  logic [2:0] height_q [NUM_COLS];
  logic [2:0] height_d [NUM_COLS];

  always_comb begin
    for (int c = 0; c < NUM_COLS; c++) begin
      height_d[c] = height_q[c];
      full_o[c]   = (height_q[c] == 3'(NUM_ROWS));
      if (inc_i && (inc_col_i == 3'(c)) && !full_o[c]) begin
        height_d[c] = height_q[c] + 3'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    for (int c = 0; c < NUM_COLS; c++) begin
      if (reset) begin
        height_q[c] <= 3'd0;
      end else begin
        height_q[c] <= height_d[c];
      end
    end
  end

  assign rd_height_o = (rd_col_i < 3'(NUM_COLS)) ? height_q[rd_col_i] : 3'd0;

endmodule

// File: rtl/turn_sequencer.sv
// Connect-four move sequencer: cursor selection, animated fall, single-cycle board write,
// then win/draw resolution and turn hand-over.
module turn_sequencer
  import turn_sequencer_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       left_key_i,
  input  logic       right_key_i,
  input  logic       drop_key_i,
  input  logic       tick_i,
  input  logic       win_i,
  output logic [2:0] cursor_col_o,
  output logic [1:0] turn_o,
  output logic       fall_active_o,
  output logic [2:0] fall_row_o,
  output logic       wr_en_o,
  output logic [2:0] wr_col_o,
  output logic [2:0] wr_row_o,
  output logic [1:0] wr_color_o,
  output logic       game_over_o,
  output logic [1:0] winner_o
);

  seq_state_e  state_q, state_d;
  logic [2:0]  cursor_q, cursor_d;
  logic [2:0]  drop_col_q, drop_col_d;
  logic [2:0]  fall_row_q, fall_row_d;
  cell_color_e turn_q, turn_d;
  cell_color_e winner_q, winner_d;
  logic [5:0]  count_q, count_d;

  logic                inc;
  logic [2:0]          rd_col;
  logic [2:0]          rd_height;
  logic [NUM_COLS-1:0] col_full;

  // While selecting, the tracker looks at the cursor; afterwards at the latched drop column.
  assign rd_col = (state_q == SELECT) ? cursor_q : drop_col_q;

  column_heights u_heights (
    .clock       (clock),
    .reset       (reset),
    .inc_i       (inc),
    .inc_col_i   (drop_col_q),
    .rd_col_i    (rd_col),
    .rd_height_o (rd_height),
    .full_o      (col_full)
  );

  always_comb begin
    state_d    = state_q;
    cursor_d   = cursor_q;
    drop_col_d = drop_col_q;
    fall_row_d = fall_row_q;
    turn_d     = turn_q;
    winner_d   = winner_q;
    count_d    = count_q;
    inc        = 1'b0;
    case (state_q)
      SELECT: begin
        // A drop key swallows any simultaneous cursor key, even when the column is full.
        if (drop_key_i) begin
          if (!col_full[cursor_q]) begin
            drop_col_d = cursor_q;
            fall_row_d = 3'(NUM_ROWS - 1);
            state_d    = FALL;
          end
        end else if (left_key_i && !right_key_i) begin
          if (cursor_q != 3'd0) cursor_d = cursor_q - 3'd1;
        end else if (right_key_i && !left_key_i) begin
          if (cursor_q != 3'(NUM_COLS - 1)) cursor_d = cursor_q + 3'd1;
        end
      end
      FALL: begin
        if (tick_i) begin
          if (fall_row_q == rd_height) state_d = WRITE;
          else fall_row_d = fall_row_q - 3'd1;
        end
      end
      WRITE: begin
        inc     = 1'b1;
        state_d = CHECK;
        if (count_q != 6'(NUM_CELLS)) count_d = count_q + 6'd1;
      end
      CHECK: begin
        if (win_i) begin
          winner_d = turn_q;
          state_d  = GAME_OVER;
        end else if (count_q == 6'(NUM_CELLS)) begin
          winner_d = EMPTY;
          state_d  = GAME_OVER;
        end else begin
          turn_d  = (turn_q == RED) ? GREEN : RED;
          state_d = SELECT;
        end
      end
      GAME_OVER: begin
      end
      default: state_d = SELECT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= SELECT;
      cursor_q   <= 3'd3;
      drop_col_q <= 3'd0;
      fall_row_q <= 3'd0;
      turn_q     <= RED;
      winner_q   <= EMPTY;
      count_q    <= 6'd0;
    end else begin
      state_q    <= state_d;
      cursor_q   <= cursor_d;
      drop_col_q <= drop_col_d;
      fall_row_q <= fall_row_d;
      turn_q     <= turn_d;
      winner_q   <= winner_d;
      count_q    <= count_d;
    end
  end

  assign wr_en_o       = (state_q == WRITE);
  assign wr_col_o      = wr_en_o ? drop_col_q : 3'd0;
  assign wr_row_o      = wr_en_o ? fall_row_q : 3'd0;
  assign wr_color_o    = wr_en_o ? turn_q : EMPTY;
  assign cursor_col_o  = cursor_q;
  assign turn_o        = turn_q;
  assign fall_active_o = (state_q == FALL);
  assign fall_row_o    = fall_row_q;
  assign game_over_o   = (state_q == GAME_OVER);
  assign winner_o      = winner_q;

endmodule

// File: tb/tb_turn_sequencer.sv
// Self-checking bench for turn_sequencer: board writes go through an expected-write scoreboard.
module tb_turn_sequencer;

  logic       clock = 1'b0;
  logic       reset, left_key, right_key, drop_key, tick, win;
  logic [2:0] cursor_col, fall_row, wr_col, wr_row;
  logic [1:0] turn, wr_color, winner;
  logic       fall_active, wr_en, game_over;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;

  typedef struct packed {
    logic [2:0] col;
    logic [2:0] row;
    logic [1:0] color;
  } wr_t;
  wr_t exp_q[$];

  // Reference model of the game state.
  int         m_cursor, m_cnt;
  int         m_h[7];
  logic [1:0] m_turn, m_winner;
  logic       m_over;

  always #5 clock = ~clock;

  turn_sequencer dut (
    .clock         (clock),
    .reset         (reset),
    .left_key_i    (left_key),
    .right_key_i   (right_key),
    .drop_key_i    (drop_key),
    .tick_i        (tick),
    .win_i         (win),
    .cursor_col_o  (cursor_col),
    .turn_o        (turn),
    .fall_active_o (fall_active),
    .fall_row_o    (fall_row),
    .wr_en_o       (wr_en),
    .wr_col_o      (wr_col),
    .wr_row_o      (wr_row),
    .wr_color_o    (wr_color),
    .game_over_o   (game_over),
    .winner_o      (winner)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(posedge clock) begin
    wr_t e;
    #1;
    if (wr_en === 1'b1) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        check_val("wr_unexpected", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check_val("wr_col", wr_col, e.col);
        check_val("wr_row", wr_row, e.row);
        check_val("wr_color", wr_color, e.color);
      end
    end
  end

  task automatic apply_reset();
    reset = 1'b1; left_key = 1'b0; right_key = 1'b0; drop_key = 1'b0; tick = 1'b0; win = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    m_cursor = 3; m_turn = 2'b01; m_cnt = 0; m_over = 1'b0; m_winner = 2'b00;
    foreach (m_h[i]) m_h[i] = 0;
    exp_q.delete();
  endtask

  task automatic press(input bit l, input bit r, input bit d);
    left_key = l; right_key = r; drop_key = d;
    @(negedge clock);
    left_key = 1'b0; right_key = 1'b0; drop_key = 1'b0;
    if (!m_over && !d) begin
      if (l && !r && m_cursor > 0) m_cursor--;
      else if (r && !l && m_cursor < 6) m_cursor++;
    end
  endtask

  task automatic goto_col(input int col);
    while (m_cursor < col) press(0, 1, 0);
    while (m_cursor > col) press(1, 0, 0);
    check_val("goto_cursor", cursor_col, m_cursor);
  endtask

  task automatic do_move(input int col, input bit win_val, input int gap, input bit chk_rows);
    int w0, exp_row;
    bit full;
    goto_col(col);
    full = (m_h[col] == 6);
    win  = win_val;
    w0   = wr_cnt;
    if (!full) exp_q.push_back(wr_t'{3'(col), 3'(m_h[col]), m_turn});
    // Right key rides along with the drop: the drop must win.
    press(0, !full, 1);
    if (full) begin
      tick = 1'b1;
      repeat (8) @(negedge clock);
      tick = 1'b0;
      win  = 1'b0;
      check_val("full_no_fall", fall_active, 0);
      check_val("full_no_wr", wr_cnt, w0);
      check_val("full_turn", turn, m_turn);
      return;
    end
    exp_row = 5;
    for (int cyc = 0; cyc < 400 && wr_cnt == w0; cyc++) begin
      if (cyc % gap == 0) begin
        if (chk_rows) begin
          check_val("fall_active", fall_active, 1);
          check_val("fall_row", fall_row, exp_row);
        end
        tick = 1'b1;
        if (exp_row > m_h[col]) exp_row--;
      end else begin
        tick = 1'b0;
      end
      @(negedge clock);
    end
    tick = 1'b0;
    if (wr_cnt == w0) check_val("wr_timeout", 0, 1);
    check_val("cursor_frozen", cursor_col, m_cursor);
    @(negedge clock);
    @(negedge clock);
    win = 1'b0;
    m_h[col]++;
    m_cnt++;
    if (win_val) begin
      m_over = 1'b1; m_winner = m_turn;
    end else if (m_cnt == 42) begin
      m_over = 1'b1; m_winner = 2'b00;
    end else begin
      m_turn = m_turn ^ 2'b11;
    end
    check_val("turn", turn, m_turn);
    check_val("game_over", game_over, m_over);
    check_val("winner", winner, m_winner);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int exp_c[4];
    int w0;
    exp_c = '{4, 5, 6, 6};
    @(negedge clock);
    apply_reset();
    check_val("rst_cursor", cursor_col, 3);
    check_val("rst_turn", turn, 2'b01);
    check_val("rst_game_over", game_over, 0);
    check_val("rst_winner", winner, 0);
    check_val("rst_fall_active", fall_active, 0);
    check_val("rst_fall_row", fall_row, 0);
    check_val("rst_wr_en", wr_en, 0);
    check_val("rst_wr_color", wr_color, 0);

    // Cursor movement and saturation.
    for (int i = 0; i < 4; i++) begin
      press(0, 1, 0);
      check_val("cursor_right", cursor_col, exp_c[i]);
    end
    press(1, 1, 0);
    check_val("cursor_both", cursor_col, 6);
    repeat (7) press(1, 0, 0);
    check_val("cursor_left_sat", cursor_col, 0);

    // First drop in column 3, slow ticks, row sequence checked.
    apply_reset();
    do_move(3, 1'b0, 4, 1'b1);
    check_val("first_turn_green", turn, 2'b10);

    // Fill column 0, try one more, then red wins on the 7th piece.
    apply_reset();
    for (int i = 0; i < 6; i++) do_move(0, 1'b0, 1, 1'b0);
    do_move(0, 1'b0, 1, 1'b0);
    do_move(1, 1'b1, 1, 1'b0);
    check_val("win_over", game_over, 1);
    check_val("win_winner", winner, 2'b01);
    w0 = wr_cnt;
    press(0, 1, 0);
    press(0, 0, 1);
    tick = 1'b1;
    repeat (10) @(negedge clock);
    tick = 1'b0;
    check_val("over_no_wr", wr_cnt, w0);
    check_val("over_cursor_hold", cursor_col, 1);
    check_val("over_winner_hold", winner, 2'b01);

    // Reset in the middle of a fall aborts the move.
    apply_reset();
    goto_col(5);
    w0 = wr_cnt;
    press(0, 0, 1);
    tick = 1'b1;
    @(negedge clock);
    @(negedge clock);
    apply_reset();
    repeat (3) @(negedge clock);
    check_val("abort_no_wr", wr_cnt, w0);
    check_val("abort_cursor", cursor_col, 3);
    check_val("abort_turn", turn, 2'b01);
    check_val("abort_fall_active", fall_active, 0);
    do_move(5, 1'b0, 1, 1'b0);

    // Fill the whole board without a win: draw.
    apply_reset();
    for (int i = 0; i < 42; i++) do_move(i / 6, 1'b0, 1, 1'b0);
    check_val("draw_over", game_over, 1);
    check_val("draw_winner", winner, 2'b00);
    check_val("draw_writes_done", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
